digit_serial_addsub: RTL and testbench

//   Parametrised add/subtract unit that processes DIGIT bits per clock, LSB digit first,

---
 rtl/addsub_pkg.sv | 6 +
 rtl/adder_digit.sv | 24 ++
 rtl/digit_serial_addsub.sv | 81 ++++++++
 tb/tb_digit_serial_addsub.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state type and operation encodings for the digit-serial adder
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/adder_digit.sv
// adder_digit: combinational DIGIT-bit ripple adder exposing the carry into its top bit
module adder_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_top_in
);
  logic [DIGIT:0] c;
  always_comb begin
    c = '0;
    s = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
  assign co = c[DIGIT];
  assign c_top_in = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: add/subtract DIGIT bits per cycle, LSB first, with valid/ready handshakes
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = $clog2(STEPS + 1);
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("digit_serial_addsub: DIGIT must divide WIDTH and lie in 1..WIDTH");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic carry, last, co, ct;
  logic [WIDTH-1:0] ra, rb;
  logic [DIGIT-1:0] s;
  assign last = cnt == CW'(STEPS - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  adder_digit #(.DIGIT(DIGIT)) u_slice (
    .x(ra[DIGIT-1:0]),
    .y(rb[DIGIT-1:0]),
    .ci(carry),
    .s(s),
    .co(co),
    .c_top_in(ct)
  );
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
  end
  // operands shift right so the active digit always sits in the low bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      ra <= '0;
      rb <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= sub == OP_SUB ? ~b : b;
        carry <= cin ^ sub;
        cnt <= '0;
      end else if (state == RUN) begin
        ra <= ra >> DIGIT;
        rb <= rb >> DIGIT;
        carry <= co;
        if (!last) cnt <= cnt + 1'b1;
        for (int i = 0; i < STEPS; i++)
          if (cnt == CW'(i)) sum[i*DIGIT +: DIGIT] <= s;
        if (last) begin
          cout <= co;
          ovf <= ct ^ co;
        end
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: lockstep check of DIGIT=1,2,4,8 instances (WIDTH=8) against vectors and an arithmetic model
module tb_digit_serial_addsub;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic ov [4], ir [4], co [4], of [4];
  logic [7:0] sm [4];
  int lat [4];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_serial_addsub #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(ov[g]), .out_ready(out_ready),
      .sum(sm[g]), .cout(co[g]), .ovf(of[g])
    );
  end

  typedef struct {
    logic [7:0] a, b;
    logic       s, c;
    logic [7:0] sum;
    logic       co, of;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // returns {ovf, cout, sum} from integer arithmetic on the operand values
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s, input logic ci);
    int ux, uy, sx, sy, c, r, sr;
    logic cy, v;
    ux = x; uy = y; c = ci;
    sx = $signed(x); sy = $signed(y);
    r  = s ? ux - uy - c : ux + uy + c;
    sr = s ? sx - sy - c : sx + sy + c;
    cy = s ? (r >= 0) : (r > 255);
    v  = (sr > 127) || (sr < -128);
    return {v, cy, r[7:0]};
  endfunction

  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic s, input logic ci);
    @(negedge clk);
    a = x; b = y; sub = s; cin = ci; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("in_ready_low_after_accept", ir[3], 1'b0);
  endtask

  task automatic wait_done(input string nm, input logic [9:0] e);
    bit all;
    for (int i = 0; i < 4; i++) lat[i] = 0;
    all = 1'b0;
    for (int cyc = 1; cyc <= 20 && !all; cyc++) begin
      @(posedge clk);
      #1;
      all = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (ov[i] && lat[i] == 0) lat[i] = cyc;
        if (lat[i] == 0) all = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s d%0d latency", nm, 1 << i), lat[i], 8 >> i);
      chk($sformatf("%s d%0d sum", nm, 1 << i), sm[i], e[7:0]);
      chk($sformatf("%s d%0d cout", nm, 1 << i), co[i], e[8]);
      chk($sformatf("%s d%0d ovf", nm, 1 << i), of[i], e[9]);
    end
  endtask

  task automatic release_out(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s d%0d out_valid_drop", nm, 1 << i), ov[i], 1'b0);
      chk($sformatf("%s d%0d in_ready_back", nm, 1 << i), ir[i], 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] x, y;
    logic s, c;
    tbl[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'hAA, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset d%0d out_valid", 1 << i), ov[i], 1'b0);
      chk($sformatf("reset d%0d in_ready", 1 << i), ir[i], 1'b1);
      chk($sformatf("reset d%0d sum", 1 << i), sm[i], 8'h00);
      chk($sformatf("reset d%0d cout", 1 << i), co[i], 1'b0);
      chk($sformatf("reset d%0d ovf", 1 << i), of[i], 1'b0);
    end
    rst = 1'b0;

    for (int t = 0; t < 6; t++) begin
      start_op(tbl[t].a, tbl[t].b, tbl[t].s, tbl[t].c);
      wait_done($sformatf("vec%0d", t), {tbl[t].of, tbl[t].co, tbl[t].sum});
      release_out($sformatf("vec%0d", t));
    end

    // result held while out_ready stays low; operands offered meanwhile are ignored
    start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_done("hold", {1'b0, 1'b0, 8'h4B});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 8'h11; b = 8'h22; in_valid = (k == 1);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d out_valid", k), ov[1], 1'b1);
      chk($sformatf("hold%0d in_ready", k), ir[1], 1'b0);
      chk($sformatf("hold%0d sum", k), sm[1], 8'h4B);
      chk($sformatf("hold%0d cout", k), co[1], 1'b0);
      chk($sformatf("hold%0d ovf", k), of[1], 1'b0);
    end
    in_valid = 1'b0;
    release_out("hold");
    @(posedge clk);
    #1;
    chk("hold ignored_ops out_valid", ov[1], 1'b0);

    // reset while the DIGIT=2 instance is on step 2
    start_op(8'h55, 8'h33, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("abort d%0d out_valid", 1 << i), ov[i], 1'b0);
      chk($sformatf("abort d%0d in_ready", 1 << i), ir[i], 1'b1);
      chk($sformatf("abort d%0d sum", 1 << i), sm[i], 8'h00);
    end
    start_op(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done("after_abort", {1'b0, 1'b0, 8'h30});
    release_out("after_abort");

    for (int n = 0; n < 40; n++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom);
      c = 1'($urandom);
      start_op(x, y, s, c);
      wait_done($sformatf("rand%0d %h%s%h c%0d", n, x, s ? "-" : "+", y, c), model(x, y, s, c));
      release_out($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
